line_setup_fifo: RTL and testbench
==================================

# line_setup_fifo

Upstream neighbour of the line generator. Accepts clipped line endpoints from the clipper and computes signed deltas and slope sign. Packs each line into the 69-bit line record and buffers records in a show-ahead FIFO read directly by the line generator. It also produces the end-of-object flag the line generator samples, qualified so it never runs ahead of lines still in flight.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, 4..64.
- `X_MAX`, 639 — largest legal x coordinate.
- `Y_MAX`, 479 — largest legal y coordinate.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `in_valid` in 1 — clipper presents a line.
- `in_ready` out 1 — block can accept a line this cycle.
- `in_x0`, `in_y0`, `in_x1`, `in_y1` in 10 each — endpoint coordinates, unsigned.
- `in_color` in 3 — line colour.
- `in_accept` in 1 — clipper verdict: 1 = line visible.
- `eoo_in` in 1 — end-of-object level from the clipper; sampled as a rising edge.
- `frame_start` in 1 — start of a new frame; clears end-of-object tracking.
- `fifo_data` out 69 — head record (show-ahead).
- `fifo_empty` out 1 — no record stored.
- `fifo_rd_en` in 1 — pop the head at the clock edge.
- `eoo_out` out 1 — end of object, drained into the FIFO.
- `fifo_count` out $clog2(DEPTH)+1 — stored records.
- `underflow_err` out 1 — sticky; pop attempted while empty.

## Operation
- Record layout, MSB first:
  - [68:59] x0
  - [58:49] y0
  - [48:39] x1
  - [38:29] y1
  - [28:18] dy
  - [17:7] dx
  - [6:4] colour
  - [3] valid
  - [2:1] 2'b00
  - [0] p_or_n
- dx = {1'b0,x1} − {1'b0,x0} and dy = {1'b0,y1} − {1'b0,y0}, both 11-bit two's complement; no overflow is possible.
- p_or_n = ~(dx[10] ^ dy[10]). Result is 1 when both deltas are non-negative or both are negative; a zero delta counts as non-negative.
- valid = in_accept & (x0,x1 ≤ X_MAX) & (y0,y1 ≤ Y_MAX).
- Pipeline:
  - Stage S1 registers the inputs and computes the deltas.
  - Stage S2 computes valid and p_or_n, packs the record and writes the FIFO.
  - Each stage has its own valid bit.
- Handshake: transfer occurs when in_valid & in_ready.
  - in_ready = (fifo_count + S1 occupancy + S2 occupancy) < DEPTH, which guarantees S2 never stalls.
  - The FIFO never overflows.
- FIFO: circular buffer with read/write pointers. Simultaneous write and pop leave fifo_count unchanged.
- Pop while empty has no effect on data or pointers and sets underflow_err. Only rst clears underflow_err.
- End-of-object:
  - A rising edge of eoo_in sets eoo_seen.
  - eoo_out = eoo_seen & ~S1 occupied & ~S2 occupied.
  - frame_start clears eoo_seen. If frame_start and an eoo_in rise occur in the same cycle, frame_start wins.
- A line accepted in the same cycle as an eoo_in rise belongs to the ending object, so eoo_out waits for it.
- rst mid-operation discards pipeline contents and all stored records.

## Timing
- Reset values:
  - in_ready = 1 (DEPTH > 0)
  - fifo_empty = 1
  - fifo_data = 0
  - fifo_count = 0
  - eoo_out = 0
  - underflow_err = 0
- Latency: line accepted at edge N is written at edge N+2. fifo_empty falls after edge N+2; fifo_data is valid in that same cycle.
- fifo_data changes only after a pop or a write into an empty FIFO; otherwise it holds.
- eoo_out rises the cycle after both pipeline stages are empty and eoo_seen is set. Earliest case: 1 cycle after an eoo_in rise with an idle pipeline.
- Throughput: one line per cycle while in_ready is high.

## Configuration
- `LINE_SETUP_DROP_INVALID_EN` defined: records with valid = 0 are not written. They free their in_ready slot at S2, and eoo_out still waits for them to clear the pipeline.
- Not defined: invalid records are stored with bit 3 = 0, and the line generator skips them.

## Structure
- Shared package `raster_pkg` holds:
  - record bit-position localparams
  - `LINE_REC_W` = 69
  - coordinate width 10 and delta width 11
  - default X_MAX and Y_MAX
- Sub-module `line_rec_fifo`: parameterised show-ahead FIFO providing data/empty/count/rd/wr. The parent owns the pipeline, packing and end-of-object logic.

## Test plan
- Line (10,20)→(100,50), colour 5, accept=1 → after 2 cycles, fifo_data fields: dx=90, dy=30, p_or_n=1, valid=1, colour=5.
- Line (100,50)→(10,400) → dx=−90 (11'h7A6), dy=350, p_or_n=0.
- Line x1=640 with accept=1 → valid=0. With `LINE_SETUP_DROP_INVALID_EN` defined, fifo_empty stays 1.
- DEPTH=4, in_valid held high, no pops → exactly 4 accepted; in_ready=0 until a pop, then in_ready=1 the next cycle. Data order preserved.
- eoo_in rises in the same cycle a line is accepted → eoo_out is low until the record is written, then high 1 cycle later. A later frame_start clears it.
- fifo_rd_en while empty → fifo_count stays 0 and underflow_err=1 until rst. rst asserted while 3 lines are stored → fifo_empty=1 next cycle.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster definitions: line record layout, field widths, default screen limits.
package raster_pkg;

    localparam int COORD_W    = 10;
    localparam int DELTA_W    = 11;
    localparam int COLOR_W    = 3;
    localparam int LINE_REC_W = 69;

    localparam int DEF_X_MAX  = 639;
    localparam int DEF_Y_MAX  = 479;

    // Line record bit positions (MSB first)
    localparam int REC_X0_MSB  = 68;
    localparam int REC_X0_LSB  = 59;
    localparam int REC_Y0_MSB  = 58;
    localparam int REC_Y0_LSB  = 49;
    localparam int REC_X1_MSB  = 48;
    localparam int REC_X1_LSB  = 39;
    localparam int REC_Y1_MSB  = 38;
    localparam int REC_Y1_LSB  = 29;
    localparam int REC_DY_MSB  = 28;
    localparam int REC_DY_LSB  = 18;
    localparam int REC_DX_MSB  = 17;
    localparam int REC_DX_LSB  = 7;
    localparam int REC_COL_MSB = 6;
    localparam int REC_COL_LSB = 4;
    localparam int REC_VALID   = 3;
    localparam int REC_PN      = 0;

    // First pipeline stage contents: captured endpoints plus deltas
    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [DELTA_W-1:0] dx;
        logic [DELTA_W-1:0] dy;
        logic [COLOR_W-1:0] color;
        logic               accept;
    } line_s1_t;

    // Assemble a line record; bits [2:1] are reserved zero
    function automatic logic [LINE_REC_W-1:0] pack_line_rec(
        input line_s1_t s,
        input logic     valid,
        input logic     p_or_n
    );
        logic [LINE_REC_W-1:0] r;
        r = '0;
        r[REC_X0_MSB:REC_X0_LSB]   = s.x0;
        r[REC_Y0_MSB:REC_Y0_LSB]   = s.y0;
        r[REC_X1_MSB:REC_X1_LSB]   = s.x1;
        r[REC_Y1_MSB:REC_Y1_LSB]   = s.y1;
        r[REC_DY_MSB:REC_DY_LSB]   = s.dy;
        r[REC_DX_MSB:REC_DX_LSB]   = s.dx;
        r[REC_COL_MSB:REC_COL_LSB] = s.color;
        r[REC_VALID]               = valid;
        r[REC_PN]                  = p_or_n;
        return r;
    endfunction

endpackage

// File: rtl/line_rec_fifo.sv
// Show-ahead circular-buffer FIFO for line records. Head word is presented
// combinationally; output reads as zero while empty. Pops on empty are
// ignored and latch a sticky underflow flag.
module line_rec_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 69
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign empty   = (count == '0);
    assign pop     = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed since empty masks the output
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and sticky underflow; pointers wrap as DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (!wr_en && pop)
                count <= count - 1'b1;
            if (rd_en && empty)
                underflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/line_setup_fifo.sv
// Line setup: two-stage pipeline (deltas, then validity/slope/pack) feeding a
// show-ahead record FIFO, plus end-of-object tracking held back until the
// pipeline has drained.
// Build option: LINE_SETUP_DROP_INVALID_EN -- when defined, records whose
// valid bit is 0 are discarded at S2 instead of being stored.
module line_setup_fifo
    import raster_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COORD_W-1:0]       in_x0,
    input  logic [COORD_W-1:0]       in_y0,
    input  logic [COORD_W-1:0]       in_x1,
    input  logic [COORD_W-1:0]       in_y1,
    input  logic [COLOR_W-1:0]       in_color,
    input  logic                     in_accept,
    input  logic                     eoo_in,
    input  logic                     frame_start,
    output logic [LINE_REC_W-1:0]    fifo_data,
    output logic                     fifo_empty,
    input  logic                     fifo_rd_en,
    output logic                     eoo_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underflow_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

    line_s1_t              s1;
    logic                  s1_vld;
    logic [LINE_REC_W-1:0] s2_rec;
    logic                  s2_vld;
    logic                  in_fire;
    logic [CNT_W:0]        occ;
    logic                  rec_valid;
    logic                  rec_pn;
    logic                  wr_en;
    logic                  eoo_prev;
    logic                  eoo_seen;

    // Lines in flight reserve a FIFO slot so S2 can always write
    assign occ      = {1'b0, fifo_count} + (CNT_W+1)'(s1_vld) + (CNT_W+1)'(s2_vld);
    assign in_ready = (occ < (CNT_W+1)'(DEPTH));
    assign in_fire  = in_valid & in_ready;

    // S1: capture endpoints and form 11-bit signed deltas
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else begin
            s1_vld <= in_fire;
            if (in_fire) begin
                s1.x0     <= in_x0;
                s1.y0     <= in_y0;
                s1.x1     <= in_x1;
                s1.y1     <= in_y1;
                s1.dx     <= {1'b0, in_x1} - {1'b0, in_x0};
                s1.dy     <= {1'b0, in_y1} - {1'b0, in_y0};
                s1.color  <= in_color;
                s1.accept <= in_accept;
            end
        end
    end

    assign rec_valid = s1.accept & (s1.x0 <= XM) & (s1.x1 <= XM)
                                 & (s1.y0 <= YM) & (s1.y1 <= YM);
    // Same delta signs (zero counts as non-negative)
    assign rec_pn    = ~(s1.dx[DELTA_W-1] ^ s1.dy[DELTA_W-1]);

    // S2: hold the packed record for one cycle, then write it
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_rec <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld)
                s2_rec <= pack_line_rec(s1, rec_valid, rec_pn);
        end
    end

`ifdef LINE_SETUP_DROP_INVALID_EN
    assign wr_en = s2_vld & s2_rec[REC_VALID];
`else
    assign wr_en = s2_vld;
`endif

    line_rec_fifo #(
        .DEPTH (DEPTH),
        .W     (LINE_REC_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (s2_rec),
        .rd_en         (fifo_rd_en),
        .rd_data       (fifo_data),
        .empty         (fifo_empty),
        .count         (fifo_count),
        .underflow_err (underflow_err)
    );

    // End-of-object: latch eoo_in rising edge; frame_start takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            eoo_prev <= 1'b0;
            eoo_seen <= 1'b0;
        end else begin
            eoo_prev <= eoo_in;
            if (frame_start)
                eoo_seen <= 1'b0;
            else if (eoo_in && !eoo_prev)
                eoo_seen <= 1'b1;
        end
    end

    // Report end-of-object only once every earlier line has left the pipeline
    assign eoo_out = eoo_seen & ~s1_vld & ~s2_vld;

endmodule

// File: tb/tb_line_setup_fifo.sv
// Directed testbench for line_setup_fifo (DEPTH=4) with hand-computed records.
module tb_line_setup_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x0, in_y0, in_x1, in_y1;
    logic [2:0]  in_color;
    logic        in_accept;
    logic        eoo_in;
    logic        frame_start;
    logic [68:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        eoo_out;
    logic [2:0]  fifo_count;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;
    int acc;

    logic [68:0] exp1, exp2;

    always #5 clk = ~clk;

    line_setup_fifo #(.DEPTH(4), .X_MAX(639), .Y_MAX(479)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x0         (in_x0),
        .in_y0         (in_y0),
        .in_x1         (in_x1),
        .in_y1         (in_y1),
        .in_color      (in_color),
        .in_accept     (in_accept),
        .eoo_in        (eoo_in),
        .frame_start   (frame_start),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .eoo_out       (eoo_out),
        .fifo_count    (fifo_count),
        .underflow_err (underflow_err)
    );

    task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int x0, input int y0, input int x1, input int y1,
                            input int col, input logic acc_in);
        in_x0     = 10'(x0);
        in_y0     = 10'(y0);
        in_x1     = 10'(x1);
        in_y1     = 10'(y1);
        in_color  = 3'(col);
        in_accept = acc_in;
    endtask

    task automatic pop();
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; fifo_rd_en = 1'b0;
        eoo_in = 1'b0; frame_start = 1'b0;
        set_line(0, 0, 0, 0, 0, 1'b0);
        // x0,y0,x1,y1,dy,dx,col,valid,00,pn
        exp1 = {10'd10, 10'd20, 10'd100, 10'd50, 11'd30, 11'd90, 3'd5, 1'b1, 2'b00, 1'b1};
        exp2 = {10'd100, 10'd50, 10'd10, 10'd400, 11'd350, 11'h7A6, 3'd2, 1'b1, 2'b00, 1'b0};
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 69'(in_ready), 69'(1));
        chk("rst_empty", 69'(fifo_empty), 69'(1));
        chk("rst_data", fifo_data, 69'(0));
        chk("rst_count", 69'(fifo_count), 69'(0));
        chk("rst_eoo", 69'(eoo_out), 69'(0));
        chk("rst_uflow", 69'(underflow_err), 69'(0));

        // Line 1: positive slope, latency 2
        set_line(10, 20, 100, 50, 5, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("l1_empty_n1", 69'(fifo_empty), 69'(1));
        tick();
        chk("l1_empty_n2", 69'(fifo_empty), 69'(1));
        tick();
        chk("l1_empty", 69'(fifo_empty), 69'(0));
        chk("l1_data", fifo_data, exp1);
        chk("l1_dx", 69'(fifo_data[17:7]), 69'(90));
        chk("l1_dy", 69'(fifo_data[28:18]), 69'(30));
        chk("l1_count", 69'(fifo_count), 69'(1));
        tick();
        chk("l1_hold", fifo_data, exp1);
        pop();
        chk("l1_pop_empty", 69'(fifo_empty), 69'(1));

        // Line 2: negative dx, positive dy
        set_line(100, 50, 10, 400, 2, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("l2_data", fifo_data, exp2);
        chk("l2_pn", 69'(fifo_data[0]), 69'(0));
        pop();

        // Out-of-range x1 -> invalid record
        set_line(0, 0, 640, 10, 1, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
`ifdef LINE_SETUP_DROP_INVALID_EN
        chk("inv_dropped", 69'(fifo_empty), 69'(1));
`else
        chk("inv_stored", 69'(fifo_empty), 69'(0));
        chk("inv_valid", 69'(fifo_data[3]), 69'(0));
        pop();
`endif

        // Fill: in_valid held, no pops -> exactly DEPTH accepted
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_line(acc + 1, 1, 5, 5, 3, 1'b1);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_acc", 69'(acc), 69'(4));
        chk("fill_ready", 69'(in_ready), 69'(0));
        chk("fill_count", 69'(fifo_count), 69'(4));
        chk("fill_head0", 69'(fifo_data[68:59]), 69'(1));
        pop();
        chk("fill_ready_after", 69'(in_ready), 69'(1));
        for (int i = 2; i <= 4; i++) begin
            chk("fill_order", 69'(fifo_data[68:59]), 69'(i));
            pop();
        end
        chk("fill_drained", 69'(fifo_empty), 69'(1));

        // EOO with a line accepted in the same cycle
        set_line(10, 20, 100, 50, 5, 1'b1);
        in_valid = 1'b1;
        eoo_in = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("eoo_wait1", 69'(eoo_out), 69'(0));
        tick();
        chk("eoo_wait2", 69'(eoo_out), 69'(0));
        tick();
        chk("eoo_written", 69'(fifo_empty), 69'(0));
        chk("eoo_high", 69'(eoo_out), 69'(1));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("eoo_frame_clr", 69'(eoo_out), 69'(0));
        // Earliest case: idle pipeline
        eoo_in = 1'b0;
        tick();
        eoo_in = 1'b1;
        tick();
        chk("eoo_idle", 69'(eoo_out), 69'(1));
        // frame_start and rising edge together: frame_start wins
        eoo_in = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        eoo_in = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("eoo_fs_wins", 69'(eoo_out), 69'(0));
        eoo_in = 1'b0;

        // Underflow: drain the one record, then pop empty
        pop();
        chk("uf_pre", 69'(underflow_err), 69'(0));
        pop();
        chk("uf_count", 69'(fifo_count), 69'(0));
        chk("uf_set", 69'(underflow_err), 69'(1));
        tick(); tick();
        chk("uf_sticky", 69'(underflow_err), 69'(1));

        // Reset with 3 stored lines
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_line(i, 0, 0, 0, 1, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("rs_count3", 69'(fifo_count), 69'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_empty", 69'(fifo_empty), 69'(1));
        chk("rs_count0", 69'(fifo_count), 69'(0));
        chk("rs_uflow", 69'(underflow_err), 69'(0));
        chk("rs_data", fifo_data, 69'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
